// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state and grant encodings.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyD = 2'd1,
    StBusyI = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GntNone  = 2'd0,
    GntData  = 2'd1,
    GntInstr = 2'd2
  } grant_e;

  function automatic logic is_busy(state_e st);
    return (st == StBusyD) || (st == StBusyI);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter, bundled as one interface.
interface mem_port_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            IReqF;
  logic [XLEN-1:0] PCF;
  logic            StallFHaz;
  logic            DReqM;
  logic            DWeM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic            MemReq;
  logic            MemWe;
  logic [XLEN-1:0] MemAddr;
  logic [XLEN-1:0] MemWData;
  logic [XLEN-1:0] MemRData;
  logic            MemReady;
  logic [XLEN-1:0] InstrF;
  logic [XLEN-1:0] ReadDataM;
  logic            StallMem;
  logic            MemErr;

  // Arbiter view.
  modport slave (
    input  IReqF, PCF, StallFHaz, DReqM, DWeM, ALUResultM, WriteDataM, MemRData, MemReady,
    output MemReq, MemWe, MemAddr, MemWData, InstrF, ReadDataM, StallMem, MemErr
  );

  // Pipeline plus memory view.
  modport master (
    output IReqF, PCF, StallFHaz, DReqM, DWeM, ALUResultM, WriteDataM, MemRData, MemReady,
    input  MemReq, MemWe, MemAddr, MemWData, InstrF, ReadDataM, StallMem, MemErr
  );
endinterface

// File: rtl/mem_port_arbiter_timer.sv
// Per-access wait counter with a sticky timeout flag for hung memory.
module mem_port_arbiter_timer #(
  parameter int unsigned MaxWait = 15,
  parameter int unsigned WaitW   = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic ready_i,
  output logic err_o
);

  logic [WaitW-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             at_max;

  always_comb begin
    at_max = (cnt_q == WaitW'(MaxWait));
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_max) begin
      // Saturate so a very long wait never wraps back below the limit.
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | (en_i & ~ready_i & at_max);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF fetch and MEM load/store; data wins, fetch follows.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  state_e          state_q, state_d;
  logic            d_done_q, d_done_d;
  logic            i_done_q, i_done_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;

  grant_e          gnt;
  logic            pend_d, pend_i;
  logic            issue, complete, d_cpl, i_cpl, load_cpl, stall;
  logic            mem_req, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic            mem_err;

  always_comb begin
    pend_d    = bus.DReqM & ~d_done_q;
    pend_i    = bus.IReqF & ~i_done_q;
    gnt       = GntNone;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    issue     = 1'b0;
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;

    // Under reset the port is silent and any in-flight access is dropped.
    if (!reset) begin
      case (state_q)
        StIdle: begin
          if (pend_d) begin
            gnt       = GntData;
            mem_req   = 1'b1;
            mem_we    = bus.DWeM;
            mem_addr  = bus.ALUResultM;
            mem_wdata = bus.WriteDataM;
          end else if (pend_i) begin
            gnt      = GntInstr;
            mem_req  = 1'b1;
            mem_addr = bus.PCF;
          end
          if (mem_req) begin
            issue   = 1'b1;
            addr_d  = mem_addr;
            we_d    = mem_we;
            wdata_d = mem_wdata;
            if (!bus.MemReady) begin
              state_d = (gnt == GntData) ? StBusyD : StBusyI;
            end
          end
        end
        StBusyD, StBusyI: begin
          gnt       = (state_q == StBusyD) ? GntData : GntInstr;
          mem_req   = 1'b1;
          mem_we    = we_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          if (bus.MemReady) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    complete = mem_req & bus.MemReady;
    d_cpl    = complete & (gnt == GntData);
    i_cpl    = complete & (gnt == GntInstr);
    load_cpl = d_cpl & ~mem_we;

    stall = ~reset & ((bus.DReqM & ~(d_done_q | d_cpl)) | (bus.IReqF & ~(i_done_q | i_cpl)));

    // Done flags survive only while the pipeline is frozen; fetch also waits out StallFHaz.
    d_done_d = stall ? (d_done_q | d_cpl) : 1'b0;
    i_done_d = (!stall && !bus.StallFHaz) ? 1'b0 : (i_done_q | i_cpl);

    data_d  = load_cpl ? bus.MemRData : data_q;
    instr_d = i_cpl ? bus.MemRData : instr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      d_done_q <= 1'b0;
      i_done_q <= 1'b0;
      instr_q  <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      d_done_q <= d_done_d;
      i_done_q <= i_done_d;
      instr_q  <= instr_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  mem_port_arbiter_timer #(
    .MaxWait(MAX_WAIT),
    .WaitW  (WAIT_W)
  ) u_timer (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (issue | complete),
    .en_i   (is_busy(state_q)),
    .ready_i(bus.MemReady),
    .err_o  (mem_err)
  );

  assign bus.MemReq    = mem_req;
  assign bus.MemWe     = mem_we;
  assign bus.MemAddr   = mem_addr;
  assign bus.MemWData  = mem_wdata;
  assign bus.InstrF    = i_cpl ? bus.MemRData : instr_q;
  assign bus.ReadDataM = load_cpl ? bus.MemRData : data_q;
  assign bus.StallMem  = stall;
  assign bus.MemErr    = mem_err;

endmodule
